pkt_ingress_arbiter: RTL

Ingress scheduler for the packet prioritizer's two-lane entry FIFO. It arbitrates up to `NUM_REQ` packet-header sources (`pkHeadInfo`) onto lane A and lane B of `FIFOdual`. It uses a burst-limited round-robin policy and grants at most two distinct requesters per cycle. It owns all FIFO enqueue sequencing, honours FIFO back-pressure and a software pause, and reports grant statistics.

---
 rtl/pkt_h.sv | 24 ++
 rtl/rr_find_first.sv | 34 +++
 rtl/pkt_ingress_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pkt_h.sv
// Packet header type, FIFO entry packing and arbiter state encoding.
// Shared by the ingress arbiter and its round-robin encoder.
package pkt_h;

  localparam int PKT_DWIDTH = 96;

  typedef struct packed {
    logic [31:0] sIP;
    logic [31:0] dIP;
    logic [15:0] sPort;
    logic [15:0] dPort;
  } pkHeadInfo;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } arb_state_e;

  function automatic logic [PKT_DWIDTH-1:0] pkt_pack(input pkHeadInfo h);
    return {h.sIP, h.dIP, h.sPort, h.dPort};
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Rotating priority encoder: first set bit of mask scanning upward from start, mod N.
// Purely combinational; an optional exclude index is skipped during the scan.
module rr_find_first #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  input  logic          use_excl,
  input  logic [IW-1:0] excl,
  output logic          found,
  output logic [IW-1:0] idx
);

  int            pos;
  logic [IW-1:0] pidx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    pidx  = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      pidx = IW'(pos);
      if (!found && mask[pidx] && !(use_excl && (pidx == excl))) begin
        found = 1'b1;
        idx   = pidx;
      end
    end
  end

endmodule

// File: rtl/pkt_ingress_arbiter.sv
// Burst-limited round-robin arbiter feeding two FIFO lanes; strobes/data registered, 1-cycle latency.
// Grants drop combinationally on pause or no fifo_space, and stay off for the cycle STALL is left.
module pkt_ingress_arbiter
  import pkt_h::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int DWIDTH    = PKT_DWIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  pkHeadInfo [NUM_REQ-1:0] req_info,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   fifo_space,
  input  logic                   pause,
  output logic                   fifo_a_en,
  output logic                   fifo_b_en,
  output logic [DWIDTH-1:0]      fifo_a_data,
  output logic [DWIDTH-1:0]      fifo_b_data,
  output logic [1:0]             arb_state,
  output logic [15:0]            grant_cnt
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [15:0]       grant_cnt_q, grant_cnt_d;
  logic              fifo_a_en_q, fifo_a_en_d;
  logic              fifo_b_en_q, fifo_b_en_d;
  logic [DWIDTH-1:0] fifo_a_data_q, fifo_a_data_d;
  logic [DWIDTH-1:0] fifo_b_data_q, fifo_b_data_d;

  logic              can_grant;
  logic              found_a, found_b;
  logic [IW-1:0]     a_idx, b_idx, b_start;
  logic              grant_a, grant_b;

  // rst gates the grant so requesters never see a handshake while reset is held
  assign can_grant = rst & (state_q != STALL) & fifo_space & ~pause;
  assign b_start   = (a_idx == IW'(NUM_REQ - 1)) ? '0 : a_idx + IW'(1);

  rr_find_first #(.N(NUM_REQ), .IW(IW)) u_find_a (
    .mask     (req_valid),
    .start    (rr_ptr_q),
    .use_excl (1'b0),
    .excl     ('0),
    .found    (found_a),
    .idx      (a_idx)
  );

  rr_find_first #(.N(NUM_REQ), .IW(IW)) u_find_b (
    .mask     (req_valid),
    .start    (b_start),
    .use_excl (1'b1),
    .excl     (a_idx),
    .found    (found_b),
    .idx      (b_idx)
  );

  assign grant_a = can_grant & found_a;
  assign grant_b = grant_a & found_b;

  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[a_idx] = 1'b1;
    if (grant_b) req_ready[b_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (grant_a) begin
      if (a_idx != rr_ptr_q) begin
        rr_ptr_d    = a_idx;
        burst_cnt_d = 4'd1;
      end else if (5'(burst_cnt_q) + 5'd1 >= 5'(MAX_BURST)) begin
        rr_ptr_d    = b_start;
        burst_cnt_d = 4'd0;
      end else begin
        burst_cnt_d = burst_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    grant_cnt_d   = grant_cnt_q + {15'd0, grant_a} + {15'd0, grant_b};
    fifo_a_en_d   = grant_a;
    fifo_b_en_d   = grant_b;
    fifo_a_data_d = grant_a ? DWIDTH'(pkt_pack(req_info[a_idx])) : fifo_a_data_q;
    fifo_b_data_d = grant_b ? DWIDTH'(pkt_pack(req_info[b_idx])) : fifo_b_data_q;
  end

  // Every state shares the same exits, so the transition collapses to one priority chain.
  always_comb begin
    if (pause | ~fifo_space) state_d = STALL;
    else if (|req_valid)     state_d = ACTIVE;
    else                     state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      burst_cnt_q   <= '0;
      grant_cnt_q   <= '0;
      fifo_a_en_q   <= 1'b0;
      fifo_b_en_q   <= 1'b0;
      fifo_a_data_q <= '0;
      fifo_b_data_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      grant_cnt_q   <= grant_cnt_d;
      fifo_a_en_q   <= fifo_a_en_d;
      fifo_b_en_q   <= fifo_b_en_d;
      fifo_a_data_q <= fifo_a_data_d;
      fifo_b_data_q <= fifo_b_data_d;
    end
  end

  assign arb_state   = state_q;
  assign grant_cnt   = grant_cnt_q;
  assign fifo_a_en   = fifo_a_en_q;
  assign fifo_b_en   = fifo_b_en_q;
  assign fifo_a_data = fifo_a_data_q;
  assign fifo_b_data = fifo_b_data_q;

endmodule
